// File: rtl/arith_share_arbiter.sv
// Round-robin arbiter sharing one registered add/sub unit between two requesters.
// The result register holds result and flags until the owning port consumes them.
package arith_share_arbiter_pkg;
  typedef enum logic [1:0] {
    arithop_nop = 2'd0,
    arithop_add = 2'd1,
    arithop_sub = 2'd2,
    arithop_inc = 2'd3
  } rv32_arithop;
endpackage

module arith_share_arbiter
  import arith_share_arbiter_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int unsigned INC_STEP = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [1:0]           i_req_valid,
  output logic [1:0]           o_req_ready,
  input  rv32_arithop [1:0]    i_req_op,
  input  logic [1:0][XLEN-1:0] i_req_a,
  input  logic [1:0][XLEN-1:0] i_req_b,
  output logic [1:0]           o_rsp_valid,
  input  logic [1:0]           i_rsp_ready,
  output logic [XLEN-1:0]      o_rsp_result,
  output logic                 o_rsp_zero,
  output logic                 o_rsp_lt,
  output logic                 o_rsp_ltu
);

  logic            full_q;
  logic            owner_q;
  logic            prio_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            lt_q;
  logic            ltu_q;

  logic            grant_vld;
  logic            grant_id;
  logic            drain;
  logic            accept;

  rv32_arithop     sel_op;
  logic [XLEN-1:0] sel_a;
  logic [XLEN-1:0] sel_b;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] inc_sum;
  logic [XLEN:0]   diff_ext;

  logic [XLEN-1:0] nxt_result;
  logic            nxt_zero;
  logic            nxt_lt;
  logic            nxt_ltu;

  always_comb begin
    grant_vld = |i_req_valid;
    grant_id  = 1'b0;
    case (i_req_valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = prio_q;
      default: grant_id = 1'b0;
    endcase
  end

  // A draining owner frees the register in the same cycle, so a new op can load without a bubble.
  assign drain  = full_q & i_rsp_ready[owner_q];
  assign accept = grant_vld & (~full_q | drain);

  assign o_req_ready[0] = accept & ~grant_id;
  assign o_req_ready[1] = accept & grant_id;

  assign o_rsp_valid[0] = full_q & ~owner_q;
  assign o_rsp_valid[1] = full_q & owner_q;

  assign o_rsp_result = result_q;
  assign o_rsp_zero   = zero_q;
  assign o_rsp_lt     = lt_q;
  assign o_rsp_ltu    = ltu_q;

  assign sel_op   = i_req_op[grant_id];
  assign sel_a    = i_req_a[grant_id];
  assign sel_b    = i_req_b[grant_id];
  assign sum      = sel_a + sel_b;
  assign inc_sum  = sel_a + XLEN'(INC_STEP);
  assign diff_ext = {1'b0, sel_a} - {1'b0, sel_b};

  always_comb begin
    nxt_result = '0;
    nxt_zero   = 1'b1;
    nxt_lt     = 1'b0;
    nxt_ltu    = 1'b0;
    case (sel_op)
      arithop_add: begin
        nxt_result = sum;
        nxt_zero   = (sum == '0);
      end
      arithop_sub: begin
        nxt_result = diff_ext[XLEN-1:0];
        nxt_zero   = (sel_a == sel_b);
        nxt_ltu    = diff_ext[XLEN];
        // Differing signs decide directly; otherwise the difference cannot overflow.
        nxt_lt     = (sel_a[XLEN-1] ^ sel_b[XLEN-1]) ? sel_a[XLEN-1] : diff_ext[XLEN-1];
      end
      arithop_inc: begin
        nxt_result = inc_sum;
        nxt_zero   = (inc_sum == '0);
      end
      default: begin
        nxt_result = '0;
        nxt_zero   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      full_q   <= 1'b0;
      owner_q  <= 1'b0;
      prio_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      lt_q     <= 1'b0;
      ltu_q    <= 1'b0;
    end else if (accept) begin
      full_q   <= 1'b1;
      owner_q  <= grant_id;
      prio_q   <= ~grant_id;
      result_q <= nxt_result;
      zero_q   <= nxt_zero;
      lt_q     <= nxt_lt;
      ltu_q    <= nxt_ltu;
    end else if (drain) begin
      full_q   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arith_share_arbiter.sv
// Bench for arith_share_arbiter: directed scenarios plus a randomized run against
// a transaction-level reference model.
module tb_arith_share_arbiter;
  import arith_share_arbiter_pkg::*;

  localparam int XLEN = 32;

  logic                 clk;
  logic                 rst_n;
  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  rv32_arithop [1:0]    req_op;
  logic [1:0][XLEN-1:0] req_a;
  logic [1:0][XLEN-1:0] req_b;
  logic [1:0]           rsp_valid;
  logic [1:0]           rsp_ready;
  logic [XLEN-1:0]      rsp_result;
  logic                 rsp_zero;
  logic                 rsp_lt;
  logic                 rsp_ltu;

  int errors = 0;
  int checks = 0;

  // reference model state: the one held response and the tie-break port
  bit              m_full;
  int              m_owner;
  int              m_prio;
  logic [XLEN-1:0] m_res;
  logic [2:0]      m_flags;

  arith_share_arbiter #(.XLEN(XLEN), .INC_STEP(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_op(req_op), .i_req_a(req_a), .i_req_b(req_b),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_result(rsp_result), .o_rsp_zero(rsp_zero),
    .o_rsp_lt(rsp_lt), .o_rsp_ltu(rsp_ltu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // returns {result, zero, lt, ltu}
  function automatic logic [XLEN+2:0] ref_op(rv32_arithop op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    case (op)
      arithop_add: begin r = a + b; return {r, r == 0, 1'b0, 1'b0}; end
      arithop_sub: begin
        r = a - b;
        return {r, a == b, $signed(a) < $signed(b), a < b};
      end
      arithop_inc: begin r = a + 32'd4; return {r, r == 0, 1'b0, 1'b0}; end
      default:     return {{XLEN{1'b0}}, 1'b1, 1'b0, 1'b0};
    endcase
  endfunction

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_op[0] = arithop_nop; req_op[1] = arithop_nop;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    m_full  = 0;
    m_owner = 0;
    m_prio  = 0;
    m_res   = '0;
    m_flags = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready_idle got=%b exp=00", req_ready); end
    req_valid = 2'b01; #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_ready_p0 got=%b exp=01", req_ready); end
    req_valid = 2'b11; #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_ready_tie got=%b exp=01", req_ready); end
    req_valid = 2'b10; #1;
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL reset_ready_p1 got=%b exp=10", req_ready); end
    req_valid = 2'b00;
  endtask

  task automatic test_sub_port0();
    @(negedge clk);
    rsp_ready = 2'b11;
    req_valid = 2'b01; req_op[0] = arithop_sub; req_a[0] = 32'd5; req_b[0] = 32'd7;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL sub0_ready got=%b exp=01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00; #1;
    checks++;
    if (rsp_valid !== 2'b01) begin errors++; $display("FAIL sub0_rsp_valid got=%b exp=01", rsp_valid); end
    checks++;
    if (rsp_result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub0_result got=%h exp=fffffffe", rsp_result); end
    checks++;
    if ({rsp_zero, rsp_lt, rsp_ltu} !== 3'b011) begin errors++; $display("FAIL sub0_flags got=%b exp=011", {rsp_zero, rsp_lt, rsp_ltu}); end
    @(negedge clk); #1;
    checks++;
    if (rsp_valid !== 2'b00) begin errors++; $display("FAIL sub0_drained got=%b exp=00", rsp_valid); end
  endtask

  task automatic test_port1_flags();
    @(negedge clk);
    rsp_ready = 2'b11;
    req_valid = 2'b10; req_op[1] = arithop_sub; req_a[1] = 32'h8000_0000; req_b[1] = 32'd1;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL p1sub_ready got=%b exp=10", req_ready); end
    @(negedge clk);
    req_op[1] = arithop_add; req_a[1] = 32'hFFFF_FFFF; req_b[1] = 32'd1;
    #1;
    checks++;
    if (rsp_valid !== 2'b10) begin errors++; $display("FAIL p1sub_rsp_valid got=%b exp=10", rsp_valid); end
    checks++;
    if (rsp_result !== 32'h7FFF_FFFF) begin errors++; $display("FAIL p1sub_result got=%h exp=7fffffff", rsp_result); end
    checks++;
    if ({rsp_zero, rsp_lt, rsp_ltu} !== 3'b010) begin errors++; $display("FAIL p1sub_flags got=%b exp=010", {rsp_zero, rsp_lt, rsp_ltu}); end
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL p1_b2b_ready got=%b exp=10", req_ready); end
    @(negedge clk);
    req_valid = 2'b00; #1;
    checks++;
    if (rsp_result !== 32'h0) begin errors++; $display("FAIL p1add_result got=%h exp=0", rsp_result); end
    checks++;
    if ({rsp_zero, rsp_lt, rsp_ltu} !== 3'b100) begin errors++; $display("FAIL p1add_flags got=%b exp=100", {rsp_zero, rsp_lt, rsp_ltu}); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [XLEN-1:0] exp_res;
    int k;
    apply_reset();
    rsp_ready = 2'b11;
    for (int i = 0; i <= 6; i++) begin
      if (i > 0) @(negedge clk);
      if (i < 6) begin
        req_valid = 2'b11;
        req_op[0] = arithop_add; req_a[0] = 32'h10 * i;     req_b[0] = 32'h1000;
        req_op[1] = arithop_add; req_a[1] = 32'h10 * i + 1; req_b[1] = 32'h2000;
      end else begin
        req_valid = 2'b00;
      end
      #1;
      if (i < 6) begin
        checks++;
        if (req_ready !== ((i % 2 == 1) ? 2'b10 : 2'b01))
          begin errors++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, req_ready, (i % 2 == 1) ? 2'b10 : 2'b01); end
      end
      if (i > 0) begin
        k = (i - 1) % 2;
        exp_res = 32'h10 * (i - 1) + k + ((k == 1) ? 32'h2000 : 32'h1000);
        checks++;
        if (rsp_valid !== ((k == 1) ? 2'b10 : 2'b01))
          begin errors++; $display("FAIL rr_owner[%0d] got=%b exp=%b", i - 1, rsp_valid, (k == 1) ? 2'b10 : 2'b01); end
        checks++;
        if (rsp_result !== exp_res)
          begin errors++; $display("FAIL rr_result[%0d] got=%h exp=%h", i - 1, rsp_result, exp_res); end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    apply_reset();
    rsp_ready = 2'b00;
    req_valid = 2'b01; req_op[0] = arithop_inc; req_a[0] = 32'h100; req_b[0] = 32'hDEAD;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL stall_first_ready got=%b exp=01", req_ready); end
    @(negedge clk);
    // port 1 raises rsp_ready while port 0 owns the register; it must not drain it
    rsp_ready = 2'b10;
    req_valid = 2'b10; req_op[1] = arithop_sub; req_a[1] = 32'd9; req_b[1] = 32'd3;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== 2'b01) begin errors++; $display("FAIL stall_valid[%0d] got=%b exp=01", c, rsp_valid); end
      checks++;
      if (rsp_result !== 32'h104) begin errors++; $display("FAIL stall_result[%0d] got=%h exp=104", c, rsp_result); end
      checks++;
      if (req_ready !== 2'b00) begin errors++; $display("FAIL stall_ready[%0d] got=%b exp=00", c, req_ready); end
    end
    @(negedge clk);
    rsp_ready = 2'b11; #1;
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL stall_release_ready got=%b exp=10", req_ready); end
    @(negedge clk);
    req_valid = 2'b00; #1;
    checks++;
    if (rsp_valid !== 2'b10) begin errors++; $display("FAIL stall_p1_valid got=%b exp=10", rsp_valid); end
    checks++;
    if (rsp_result !== 32'd6) begin errors++; $display("FAIL stall_p1_result got=%h exp=6", rsp_result); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rsp_ready = 2'b00;
    req_valid = 2'b01; req_op[0] = arithop_add; req_a[0] = 32'd1; req_b[0] = 32'd2;
    @(negedge clk);
    req_valid = 2'b00; #1;
    checks++;
    if (rsp_valid !== 2'b01) begin errors++; $display("FAIL rstmid_before got=%b exp=01", rsp_valid); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rstmid_async got=%b exp=00", rsp_valid); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 2'b11;
    #1;
    checks++;
    if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rstmid_after got=%b exp=00", rsp_valid); end
    req_valid = 2'b11; req_op[0] = arithop_nop; req_op[1] = arithop_nop;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_tie got=%b exp=01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00; #1;
    checks++;
    if (rsp_valid !== 2'b01) begin errors++; $display("FAIL rstmid_owner got=%b exp=01", rsp_valid); end
    @(negedge clk);
  endtask

  task automatic test_nop();
    @(negedge clk);
    rsp_ready = 2'b11;
    req_valid = 2'b10; req_op[1] = arithop_nop; req_a[1] = 32'd123; req_b[1] = 32'd456;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL nop_ready got=%b exp=10", req_ready); end
    @(negedge clk);
    req_valid = 2'b00; #1;
    checks++;
    if (rsp_valid !== 2'b10) begin errors++; $display("FAIL nop_valid got=%b exp=10", rsp_valid); end
    checks++;
    if (rsp_result !== 32'h0) begin errors++; $display("FAIL nop_result got=%h exp=0", rsp_result); end
    checks++;
    if ({rsp_zero, rsp_lt, rsp_ltu} !== 3'b100) begin errors++; $display("FAIL nop_flags got=%b exp=100", {rsp_zero, rsp_lt, rsp_ltu}); end
    @(negedge clk);
  endtask

  function automatic logic [XLEN-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'hFFFF_FFFF;
      3:       return XLEN'($urandom_range(0, 8));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    bit [1:0]   hold;
    logic [1:0] exp_ready;
    logic [1:0] exp_valid;
    logic [XLEN+2:0] r;
    int  gid;
    bit  gv;
    bit  space;
    bit  drain_m;
    apply_reset();
    hold = 2'b00;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!hold[k]) begin
          req_valid[k] = ($urandom_range(0, 3) != 0);
          req_op[k]    = rv32_arithop'($urandom_range(0, 3));
          req_a[k]     = pick_operand();
          req_b[k]     = ($urandom_range(0, 3) == 0) ? req_a[k] : pick_operand();
        end
      end
      rsp_ready = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      #1;
      gv  = (req_valid != 2'b00);
      gid = (req_valid == 2'b11) ? m_prio : (req_valid[1] ? 1 : 0);
      space = !m_full || rsp_ready[m_owner];
      exp_ready = (gv && space) ? ((gid == 1) ? 2'b10 : 2'b01) : 2'b00;
      exp_valid = m_full ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
      checks++;
      if (req_ready !== exp_ready) begin errors++; $display("FAIL rand_ready[%0d] got=%b exp=%b", cyc, req_ready, exp_ready); end
      checks++;
      if (rsp_valid !== exp_valid) begin errors++; $display("FAIL rand_rsp_valid[%0d] got=%b exp=%b", cyc, rsp_valid, exp_valid); end
      if (m_full) begin
        checks++;
        if (rsp_result !== m_res) begin errors++; $display("FAIL rand_result[%0d] got=%h exp=%h", cyc, rsp_result, m_res); end
        checks++;
        if ({rsp_zero, rsp_lt, rsp_ltu} !== m_flags)
          begin errors++; $display("FAIL rand_flags[%0d] got=%b exp=%b", cyc, {rsp_zero, rsp_lt, rsp_ltu}, m_flags); end
      end
      drain_m = m_full && rsp_ready[m_owner];
      if (gv && space) begin
        r       = ref_op(req_op[gid], req_a[gid], req_b[gid]);
        m_res   = r[XLEN+2:3];
        m_flags = r[2:0];
        m_full  = 1;
        m_owner = gid;
        m_prio  = 1 - gid;
      end else if (drain_m) begin
        m_full = 0;
      end
      hold = req_valid & ~exp_ready;
    end
    @(negedge clk);
    req_valid = 2'b00;
  endtask

  initial begin
    test_reset();
    test_sub_port0();
    test_port1_flags();
    test_round_robin();
    test_stall();
    test_reset_mid();
    test_nop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
